// File: rtl/mdu_iter_pkg.sv
// Shared op codes, FSM state encoding and op-class helpers for the iterative MDU.
package mdu_iter_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        RUN  = 2'd2,
        FIX  = 2'd3
    } state_t;

    function automatic logic is_mul(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/mdu_iter_div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only when no borrow occurred.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,       // partial remainder already shifted left with next dividend bit
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);
    logic [WIDTH:0] diff;

    // The shifted remainder is < 2*divisor, so bit WIDTH of the difference is the borrow.
    always_comb begin
        diff     = rem - {1'b0, divisor};
        q_bit    = ~diff[WIDTH];
        next_rem = diff[WIDTH] ? rem[WIDTH-1:0] : diff[WIDTH-1:0];
    end
endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// IDLE -> PREP (magnitudes, signs) -> RUN (WIDTH steps) -> FIX (sign fix, write HI/LO).
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op_c, op_q;
    logic [WIDTH-1:0]   a_q, b_q, opnd;
    logic [2*WIDTH-1:0] acc;
    logic               neg_res, neg_rem;

    logic               start_md, q_mul, q_sgn, sa, sb, div0;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nx, div_nx, prod;
    logic [WIDTH-1:0]   div_rem, quot, rmd;
    logic               div_q;

    assign op_c     = op[2:0];
    assign start_md = start && (op_c <= MD_DIVU);
    assign q_mul    = is_mul(op_q);
    assign q_sgn    = is_signed_op(op_q);
    assign busy     = (state != IDLE);
    assign done     = (state == FIX) && !flush;

    // Operand magnitudes and signs for the PREP cycle.
    always_comb begin
        sa    = q_sgn & a_q[WIDTH-1];
        sb    = q_sgn & b_q[WIDTH-1];
        mag_a = sa ? -a_q : a_q;
        mag_b = sb ? -b_q : b_q;
    end

    // Shift-add multiply step: multiplier sits in the low half and shifts out LSB-first.
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_nx  = {mul_sum, acc[WIDTH-1:1]};
    end

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      ({acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]}),
        .divisor  (opnd),
        .next_rem (div_rem),
        .q_bit    (div_q)
    );

    // Divide step: remainder in the high half, dividend shifts out of the low half
    // while quotient bits shift in behind it.
    always_comb begin
        div_nx = {div_rem, acc[WIDTH-2:0], div_q};
        prod   = neg_res ? -acc : acc;
        quot   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rmd    = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        div0   = (b_q == '0);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; flush always returns to IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_md) state_nx = PREP;
            PREP:    state_nx = RUN;
            RUN:     if (cnt == '0) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    // Operand latch, PREP setup and per-cycle iteration of the accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            opnd    <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_md) begin
                    op_q <= op_c;
                    a_q  <= a;
                    b_q  <= b;
                end
                PREP: begin
                    opnd    <= q_mul ? mag_a : mag_b;
                    acc     <= {{WIDTH{1'b0}}, (q_mul ? mag_b : mag_a)};
                    neg_res <= sa ^ sb;
                    neg_rem <= sa;
                    cnt     <= CNT_W'(WIDTH - 1);
                end
                RUN: begin
                    acc <= q_mul ? mul_nx : div_nx;
                    cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // HI/LO change only on MTHI/MTLO in IDLE or at the end of FIX; flush blocks both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (!flush) begin
            if (state == IDLE && start && op_c == MD_MTHI) hi <= a;
            if (state == IDLE && start && op_c == MD_MTLO) lo <= a;
            if (state == FIX) begin
                if (q_mul) begin
                    {hi, lo} <= prod;
                end else if (div0) begin
                    hi <= a_q;
                    lo <= '1;
                end else begin
                    hi <= rmd;
                    lo <= quot;
                end
            end
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed table, corner sequences, random vs. reference model.
module tb_mdu_iter;
    import mdu_iter_pkg::*;

    logic        clk, rst, start, flush, busy, done;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi, m_lo;

    mdu_iter #(.WIDTH(32), .OP_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, returns {hi, lo}.
    function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            MD_MULT:  return 64'(sx * sy);
            MD_MULTU: return {32'h0, x} * {32'h0, y};
            MD_DIV:   if (y == 0) return {x, 32'hFFFFFFFF};
                      else return {32'(sx % sy), 32'(sx / sy)};
            default:  if (y == 0) return {x, 32'hFFFFFFFF};
                      else return {x % y, x / y};
        endcase
    endfunction

    // Issue one op from IDLE; during busy, throw random starts at the DUT (must be ignored).
    task automatic do_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] eh, input logic [31:0] el, input string nm);
        int done_at, done_cnt, busy_bad;
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(negedge clk);
        if (o <= MD_DIVU) begin
            done_at = 0; done_cnt = 0; busy_bad = 0;
            for (int k = 1; k <= 34; k++) begin
                if (k > 1) @(negedge clk);
                if (!busy) busy_bad++;
                if (done) begin
                    done_cnt++;
                    if (done_at == 0) done_at = k;
                end
                if (k < 34) begin
                    start = 1'($urandom); op = 3'($urandom); a = $urandom; b = $urandom;
                end else begin
                    start = 1'b0;
                end
            end
            @(negedge clk);
            if (busy) busy_bad++;
            if (done) done_cnt++;
            check({nm, " done_cycle"}, 64'(done_at), 64'd34);
            check({nm, " done_count"}, 64'(done_cnt), 64'd1);
            check({nm, " busy_window"}, 64'(busy_bad), 64'd0);
        end else begin
            start = 1'b0;
            check({nm, " busy_done"}, {62'h0, busy, done}, 64'd0);
        end
        check({nm, " hi"}, 64'(hi), 64'(eh));
        check({nm, " lo"}, 64'(lo), 64'(el));
        m_hi = eh;
        m_lo = el;
    endtask

    vec_t tbl[10];

    initial begin
        logic [63:0] r;
        logic [2:0]  ro;
        logic [31:0] ra, rb, eh, el;
        int          dcnt;

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(negedge clk);
        check("reset outputs", {busy, done, hi, lo}, 66'h0);
        rst = 1'b0;

        tbl[0] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tbl[1] = '{MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        tbl[2] = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3] = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        tbl[4] = '{MD_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
        tbl[5] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        tbl[6] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        tbl[7] = '{MD_DIV,   32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF};
        tbl[8] = '{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        tbl[9] = '{MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

        for (int i = 0; i < 10; i++)
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, $sformatf("tbl%0d", i));

        // MTHI: single cycle, busy never rises.
        do_op(MD_MTHI, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, m_lo, "mthi");

        // Flush at RUN cycle 10 of a DIV.
        @(negedge clk);
        start = 1'b1; op = MD_DIV; a = 32'h12345678; b = 32'h00000013;
        @(negedge clk);
        start = 1'b0;
        dcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("flush busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy_after", 64'(busy), 64'd0);
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("flush done_pulses", 64'(dcnt), 64'd0);
        check("flush hi_lo", {hi, lo}, {32'hDEADBEEF, m_lo});

        // Flush and start in the same IDLE cycle: both MTHI and DIV dropped.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = MD_MTHI; a = 32'h12345678;
        @(negedge clk);
        op = MD_DIV; a = 32'd50; b = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start busy", 64'(busy), 64'd0);
        check("flush_start hi_lo", {hi, lo}, {m_hi, m_lo});

        // NOP code: nothing happens.
        do_op(3'd6, 32'hCAFEF00D, 32'h1, m_hi, m_lo, "nop6");

        // Reset mid-RUN of a MULT.
        do_op(MD_MTLO, 32'h0BADF00D, 32'h0, m_hi, 32'h0BADF00D, "mtlo");
        @(negedge clk);
        start = 1'b1; op = MD_MULT; a = 32'h00001234; b = 32'h00005678;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid reset outputs", {busy, done, hi, lo}, 66'h0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        do_op(MD_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, "after_reset");

        // Random ops against the reference model.
        for (int n = 0; n < 40; n++) begin
            ro = 3'($urandom);
            case ($urandom_range(0, 5))
                0: ra = 32'h0; 1: ra = 32'hFFFFFFFF; 2: ra = 32'h80000000;
                3: ra = $urandom_range(0, 15); default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rb = 32'h0; 1: rb = 32'hFFFFFFFF; 2: rb = 32'h80000000;
                3: rb = $urandom_range(0, 15); default: rb = $urandom;
            endcase
            eh = m_hi; el = m_lo;
            if (ro <= MD_DIVU) begin
                r = ref_md(ro, ra, rb);
                eh = r[63:32]; el = r[31:0];
            end else if (ro == MD_MTHI) eh = ra;
            else if (ro == MD_MTLO) el = ra;
            do_op(ro, ra, rb, eh, el, $sformatf("rnd%0d op%0d a=%h b=%h", n, ro, ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
